// File: rtl/seq16_pkg.sv
// Shared widths, pin map and output-enable pattern for sequential_16bit_en.
// The optional terminal-count pin is controlled by the TC_FLAG_EN macro.
package seq16_pkg;

  localparam int IO_W    = 28;
  localparam int COUNT_W = 16;

  localparam int CLR_BIT = 0;
  localparam int EN_BIT  = 1;
  localparam int DIR_BIT = 2;

  localparam int COUNT_LSB = 4;
  localparam int COUNT_MSB = 19;
  localparam int TC_BIT    = 20;

  // Active-low enable: count pins (and tc when present) are outputs.
`ifdef TC_FLAG_EN
  localparam logic [IO_W-1:0] OEB_MASK = 28'hFE0000F;
`else
  localparam logic [IO_W-1:0] OEB_MASK = 28'hFF0000F;
`endif

endpackage

// File: rtl/counter16.sv
// 16-bit up/down counter with synchronous clear and enable.
// The tc output exists only when TC_FLAG_EN is defined.
module counter16
  import seq16_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic               dir,
`ifdef TC_FLAG_EN
  output logic               tc,
`endif
  output logic [COUNT_W-1:0] count
);

  logic [COUNT_W-1:0] count_next;

  // Clear beats enable; direction only matters while enabled.
  always_comb begin
    count_next = count;
    if (clr) begin
      count_next = '0;
    end else if (en) begin
      if (dir) count_next = count - 1'b1;
      else     count_next = count + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count <= '0;
    else     count <= count_next;
  end

`ifdef TC_FLAG_EN
  // Terminal count in the current direction, deliberately not gated by en.
  assign tc = dir ? (count == '0) : (count == '1);
`endif

endmodule

// File: rtl/sequential_16bit_en.sv
// IO-bank wrapper mapping the Caravel-style pins onto counter16.
// Build with TC_FLAG_EN defined to expose the terminal-count flag on pin 20.
module sequential_16bit_en
  import seq16_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [IO_W-1:0] io_in,
  output logic [IO_W-1:0] io_out,
  output logic [IO_W-1:0] io_oeb
);

  logic [COUNT_W-1:0] count;
`ifdef TC_FLAG_EN
  logic               tc;
`endif

  counter16 u_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (io_in[CLR_BIT]),
    .en    (io_in[EN_BIT]),
    .dir   (io_in[DIR_BIT]),
`ifdef TC_FLAG_EN
    .tc    (tc),
`endif
    .count (count)
  );

  // Upper control pins carry no function.
  logic unused_pins;
  assign unused_pins = &{1'b0, io_in[IO_W-1:DIR_BIT+1]};

  always_comb begin
    io_out = '0;
    io_out[COUNT_MSB:COUNT_LSB] = count;
`ifdef TC_FLAG_EN
    io_out[TC_BIT] = tc;
`endif
  end

  assign io_oeb = OEB_MASK;

endmodule

// File: tb/tb_sequential_16bit_en.sv
// Self-checking bench for sequential_16bit_en against an arithmetic counter model.
// Honours TC_FLAG_EN the same way as the design build.
module tb_sequential_16bit_en;

`ifdef TC_FLAG_EN
  localparam bit TC_ON = 1'b1;
  localparam logic [27:0] EXP_OEB = 28'hFE0000F;
`else
  localparam bit TC_ON = 1'b0;
  localparam logic [27:0] EXP_OEB = 28'hFF0000F;
`endif

  logic        clk;
  logic        rst;
  logic [27:0] io_in;
  logic [27:0] io_out;
  logic [27:0] io_oeb;

  int checks = 0;
  int errors = 0;
  int unsigned m_count = 0;

  sequential_16bit_en dut (
    .clk    (clk),
    .rst    (rst),
    .io_in  (io_in),
    .io_out (io_out),
    .io_oeb (io_oeb)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: plain modulo-65536 arithmetic
  function automatic logic [27:0] model_out();
    logic [27:0] v;
    v = 28'(m_count) << 4;
    if (TC_ON && ((!io_in[2] && m_count == 65535) || (io_in[2] && m_count == 0)))
      v = v | 28'h0100000;
    return v;
  endfunction

  task automatic model_edge(input logic [27:0] v);
    if (v[0])      m_count = 0;
    else if (v[1]) m_count = v[2] ? (m_count + 65535) % 65536 : (m_count + 1) % 65536;
  endtask

  // scoreboard compare
  task automatic check(input string tag, input logic [27:0] obs, input logic [27:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver: apply pins after a falling edge, check, clock once, check again
  task automatic step(input string tag, input logic [27:0] v);
    io_in = v;
    #1;
    check({tag, "_pre"}, io_out, model_out());
    @(posedge clk);
    model_edge(v);
    @(negedge clk);
    check({tag, "_post"}, io_out, model_out());
    check({tag, "_oeb"}, io_oeb, EXP_OEB);
  endtask

  initial begin
    logic [27:0] v;
    rst = 1'b1;
    io_in = '0;
    repeat (3) @(negedge clk);
    check("reset_out", io_out, 28'h0);
    check("reset_oeb", io_oeb, EXP_OEB);
    rst = 1'b0;
    m_count = 0;

    // clear dominates enable
    for (int i = 0; i < 5; i++) step("clear", 28'h3);
    check("clear_zero", io_out, 28'h0);

    // count up 100 edges
    for (int i = 0; i < 100; i++) step("up", 28'h2);
    check("up_100", {12'h0, io_out[19:4]}, 28'd100);

    // hold at 5 with random upper pins
    step("clr_hold", 28'h1);
    for (int i = 0; i < 5; i++) step("to5", 28'h2);
    for (int i = 0; i < 10; i++) begin
      v = 28'($urandom) & 28'hFFFFFF8;
      step("hold", v);
    end
    check("hold_5", {12'h0, io_out[19:4]}, 28'd5);

    // wrap up: FFFF -> 0000
    step("clr_wu", 28'h1);
    step("to_ffff", 28'h6);
    check("at_ffff", {12'h0, io_out[19:4]}, 28'h000FFFF);
    step("wrap_up", 28'h2);
    check("wrapped_0", io_out, 28'h0);

    // down from 0
    step("clr_dn", 28'h1);
    for (int i = 0; i < 5; i++) step("down", 28'h6);
    check("down_fffb", {12'h0, io_out[19:4]}, 28'h000FFFB);

    // async reset between edges
    for (int i = 0; i < 7; i++) step("pre_rst", 28'h2);
    io_in = 28'h2;
    #1 rst = 1'b1;
    #1 check("async_rst", io_out, 28'h0);
    m_count = 0;
    #1 rst = 1'b0;
    @(negedge clk);
    check("resume_1", {12'h0, io_out[19:4]}, 28'd1);
    m_count = 1;
    step("resume", 28'h2);
    check("resume_2", {12'h0, io_out[19:4]}, 28'd2);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      v = 28'($urandom);
      v[0] = ($urandom_range(0, 15) == 0);
      step("rand", v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
